// File: rtl/regfile_pkg.sv
// Shared constants and entry type for the register-file write path.
package regfile_pkg;
    localparam int REG_ID_W   = 4;
    localparam int NUM_REGS   = 16;
    localparam int DATA_W_DEF = 16;
    localparam logic [REG_ID_W-1:0] ZERO_REG = 4'd0;

    typedef struct packed {
        logic [REG_ID_W-1:0]   reg_id;
        logic [DATA_W_DEF-1:0] data;
    } wr_entry_t;
endpackage

// File: rtl/regfile_write_port_if.sv
// Write-back request handshake into the register-file write buffer.
interface regfile_write_port_if #(parameter int DATA_W = 16);
    import regfile_pkg::*;
    logic                wr_valid;
    logic                wr_ready;
    logic [REG_ID_W-1:0] wr_reg_id;
    logic [DATA_W-1:0]   wr_data;

    modport master (output wr_valid, wr_reg_id, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_reg_id, wr_data, output wr_ready);
endinterface

// File: rtl/regfile_write_port_decoder.sv
// 4-to-16 one-hot wordline decoder; all zeros when disabled.
module WriteDecoder_4_16
    import regfile_pkg::*;
(
    input  logic [REG_ID_W-1:0] RegId,
    input  logic                WriteEn,
    output logic [NUM_REGS-1:0] Wordline
);
    always_comb begin
        Wordline = '0;
        if (WriteEn) Wordline[RegId] = 1'b1;
    end
endmodule

// File: rtl/regfile_write_port.sv
// Buffered register-file write port: FIFO of pending write-backs drained one per
// cycle, with youngest-match forwarding to both read ports.
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_write_port_if.slave  wr,
    input  logic                 rf_busy,
    output logic                 WriteEnable,
    output logic [NUM_REGS-1:0]  WriteWordline,
    output logic [DATA_W-1:0]    WriteData,
    input  logic [REG_ID_W-1:0]  rd_id1,
    input  logic [REG_ID_W-1:0]  rd_id2,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic [DATA_W-1:0]    fwd_data1,
    output logic [DATA_W-1:0]    fwd_data2,
    output logic                 empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [REG_ID_W-1:0] reg_id;
        logic [DATA_W-1:0]   data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head, tail, idx;
    logic [CNT_W-1:0]   count;
    logic               full, push, pop, wl_en;

    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign wr.wr_ready = !full;
    assign push        = wr.wr_valid & !full;
    assign WriteEnable = !empty & !rf_busy;
    assign pop         = WriteEnable;
    assign WriteData   = empty ? '0 : mem[head].data;
    // R0 commits still pulse WriteEnable but must not select a wordline.
    assign wl_en       = WriteEnable && (mem[head].reg_id != ZERO_REG);

    WriteDecoder_4_16 u_dec (
        .RegId    (mem[head].reg_id),
        .WriteEn  (wl_en),
        .Wordline (WriteWordline)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[tail] <= '{reg_id: wr.wr_reg_id, data: wr.wr_data};
                tail      <= tail + PTR_W'(1);
            end
            if (pop) head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Walk oldest to youngest so the last match (nearest tail) wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (mem[idx].reg_id != ZERO_REG)) begin
                if (mem[idx].reg_id == rd_id1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = mem[idx].data;
                end
                if (mem[idx].reg_id == rd_id2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = mem[idx].data;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port (DEPTH=2, DATA_W=16).
module tb_regfile_write_port;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rf_busy;
    logic        WriteEnable;
    logic [15:0] WriteWordline;
    logic [15:0] WriteData;
    logic [3:0]  rd_id1, rd_id2;
    logic        fwd_hit1, fwd_hit2;
    logic [15:0] fwd_data1, fwd_data2;
    logic        empty;
    int          errors = 0;
    int          checks = 0;

    regfile_write_port_if #(.DATA_W(16)) wr_bus ();

    regfile_write_port #(.DEPTH(2), .DATA_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr            (wr_bus),
        .rf_busy       (rf_busy),
        .WriteEnable   (WriteEnable),
        .WriteWordline (WriteWordline),
        .WriteData     (WriteData),
        .rd_id1        (rd_id1),
        .rd_id2        (rd_id2),
        .fwd_hit1      (fwd_hit1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] id, input logic [15:0] d);
        wr_bus.wr_valid  = v;
        wr_bus.wr_reg_id = id;
        wr_bus.wr_data   = d;
    endtask

    initial begin
        rst_n = 1'b0; rf_busy = 1'b0; rd_id1 = 4'd0; rd_id2 = 4'd0;
        drive(1'b1, 4'd3, 16'h3333);
        // Reset with a request held valid
        tick(); tick();
        chk("rst_ready", wr_bus.wr_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_we", WriteEnable, 0);
        chk("rst_wl", WriteWordline, 0);
        chk("rst_wd", WriteData, 0);
        chk("rst_hit", {fwd_hit1, fwd_hit2}, 0);
        chk("rst_fwd", {fwd_data1, fwd_data2}, 0);
        drive(1'b0, 4'd0, 16'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", empty, 1);
        chk("post_rst_we", WriteEnable, 0);

        // Single write R5 = BEEF
        drive(1'b1, 4'd5, 16'hBEEF);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        rd_id1 = 4'd5;
        #1;
        chk("sw_we", WriteEnable, 1);
        chk("sw_wl", WriteWordline, 16'h0020);
        chk("sw_wd", WriteData, 16'hBEEF);
        chk("sw_empty", empty, 0);
        chk("sw_fwd_hit", fwd_hit1, 1);
        chk("sw_fwd_data", fwd_data1, 16'hBEEF);
        tick();
        chk("sw_drained", empty, 1);
        chk("sw_we_off", WriteEnable, 0);
        chk("sw_wd_off", WriteData, 0);
        chk("sw_fwd_off", fwd_hit1, 0);

        // Backpressure until full
        rf_busy = 1'b1;
        drive(1'b1, 4'd1, 16'h0001);
        tick();
        drive(1'b1, 4'd2, 16'h0002);
        tick();
        chk("bp_ready", wr_bus.wr_ready, 0);
        chk("bp_we", WriteEnable, 0);
        chk("bp_wl", WriteWordline, 0);
        drive(1'b1, 4'd3, 16'h0003);
        tick();
        chk("bp_hold_wd", WriteData, 16'h0001);
        rf_busy = 1'b0;
        #1;
        chk("bp_rel_we", WriteEnable, 1);
        chk("bp_rel_wl", WriteWordline, 16'h0002);
        chk("bp_rel_ready", wr_bus.wr_ready, 0);
        tick();
        chk("bp_r2_wl", WriteWordline, 16'h0004);
        chk("bp_r2_wd", WriteData, 16'h0002);
        chk("bp_r2_ready", wr_bus.wr_ready, 1);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        chk("bp_r3_wl", WriteWordline, 16'h0008);
        chk("bp_r3_wd", WriteData, 16'h0003);
        tick();
        chk("bp_empty", empty, 1);

        // Forwarding priority
        rf_busy = 1'b1;
        drive(1'b1, 4'd7, 16'h1111);
        tick();
        drive(1'b1, 4'd7, 16'h2222);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        rd_id1 = 4'd7; rd_id2 = 4'd4;
        #1;
        chk("fw_hit1", fwd_hit1, 1);
        chk("fw_data1", fwd_data1, 16'h2222);
        chk("fw_hit2", fwd_hit2, 0);
        chk("fw_data2", fwd_data2, 0);
        rd_id2 = 4'd7;
        #1;
        chk("fw_data2_7", fwd_data2, 16'h2222);
        rf_busy = 1'b0;
        tick();
        chk("fw_after_pop", fwd_data1, 16'h2222);
        tick();
        chk("fw_gone", fwd_hit1, 0);

        // Older match when the youngest entry is a different register
        rf_busy = 1'b1;
        drive(1'b1, 4'd7, 16'hAAAA);
        tick();
        drive(1'b1, 4'd9, 16'h9999);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        rd_id2 = 4'd9;
        #1;
        chk("fw_old_data1", fwd_data1, 16'hAAAA);
        chk("fw_young_data2", fwd_data2, 16'h9999);
        rf_busy = 1'b0;
        #1;
        chk("fw_head_writing", {fwd_hit1, fwd_data1}, {1'b1, 16'hAAAA});
        tick(); tick();
        chk("fw_drained", empty, 1);

        // R0 write
        rf_busy = 1'b1;
        rd_id1 = 4'd0;
        drive(1'b1, 4'd0, 16'hFFFF);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        chk("r0_hit", fwd_hit1, 0);
        chk("r0_fwd", fwd_data1, 0);
        chk("r0_empty", empty, 0);
        rf_busy = 1'b0;
        #1;
        chk("r0_we", WriteEnable, 1);
        chk("r0_wl", WriteWordline, 16'h0000);
        chk("r0_wd", WriteData, 16'hFFFF);
        tick();
        chk("r0_drained", empty, 1);

        // Mid-operation reset
        rf_busy = 1'b1;
        drive(1'b1, 4'd2, 16'h0022);
        tick();
        drive(1'b1, 4'd3, 16'h0033);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        rd_id1 = 4'd3;
        #1;
        chk("mr_pre_hit", fwd_hit1, 1);
        chk("mr_pre_ready", wr_bus.wr_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mr_empty", empty, 1);
        chk("mr_ready", wr_bus.wr_ready, 1);
        chk("mr_wd", WriteData, 0);
        chk("mr_hit", fwd_hit1, 0);
        chk("mr_fwd", fwd_data1, 0);
        rst_n = 1'b1;
        rf_busy = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("mr_no_we", WriteEnable, 0);
            chk("mr_no_wl", WriteWordline, 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
